// File: rtl/moore_serial_tx.sv
// Moore serial transmitter: takes a parallel word on a valid/ready handshake and
// sends it as a start bit, the data bits LSB-first and a stop bit.
module moore_serial_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              done,
  output logic [1:0]        state
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            cur_state;
  state_t            nxt_state;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              bit_end;
  logic              handshake;

  assign handshake = tx_valid && tx_ready;
  assign bit_end   = (cyc_cnt == CYC_LAST);
  assign state     = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (handshake) nxt_state = START;
      START:   if (bit_end) nxt_state = DATA;
      DATA:    if (bit_end && (bit_cnt == BIT_LAST)) nxt_state = STOP;
      STOP:    if (bit_end) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Counters restart at every bit boundary; the shift register exposes the
  // current data bit at shreg[0] and moves on only at the end of a DATA bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      done    <= 1'b0;
    end else begin
      done <= (cur_state == STOP) && bit_end;
      case (cur_state)
        IDLE: begin
          cyc_cnt <= '0;
          bit_cnt <= '0;
          if (handshake) shreg <= tx_data;
        end
        DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            shreg   <= shreg >> 1;
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: begin
          cyc_cnt <= bit_end ? '0 : cyc_cnt + 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    tx_out   = 1'b1;
    tx_ready = 1'b0;
    tx_busy  = 1'b1;
    case (cur_state)
      IDLE: begin
        tx_ready = 1'b1;
        tx_busy  = 1'b0;
      end
      START:   tx_out = 1'b0;
      DATA:    tx_out = shreg[0];
      STOP:    tx_out = 1'b1;
      default: tx_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_moore_serial_tx.sv
// Directed bench for moore_serial_tx: one instance at one clock per bit and one at
// four clocks per bit, driven from a vector table plus hand-written corner sequences.
module tb_moore_serial_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] data1, data4;
  logic       valid1, valid4;
  logic       rdy1, rdy4, out1, out4, busy1, busy4, done1, done4;
  logic [1:0] st1, st4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    int         bc;
  } vec_t;

  vec_t vecs[6];

  moore_serial_tx #(.DATA_W(8), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data1), .tx_valid(valid1),
    .tx_ready(rdy1), .tx_out(out1), .tx_busy(busy1), .done(done1), .state(st1)
  );

  moore_serial_tx #(.DATA_W(8), .BIT_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tx_data(data4), .tx_valid(valid4),
    .tx_ready(rdy4), .tx_out(out4), .tx_busy(busy4), .done(done4), .state(st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int bc, input logic [7:0] d, input bit hold);
    @(negedge clk);
    checkOutput("ready_before_send", (bc == 1) ? rdy1 : rdy4, 1);
    if (bc == 1) begin valid1 = 1'b1; data1 = d; end
    else         begin valid4 = 1'b1; data4 = d; end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (bc == 1) valid1 = 1'b0;
      else         valid4 = 1'b0;
    end
  endtask

  // Frame bits are listed in transmission order: frame[0] is the start bit.
  task automatic checkFrame(input int bc, input logic [9:0] frame);
    logic [1:0] exp_st;
    for (int i = 0; i < 10; i++) begin
      exp_st = (i == 0) ? 2'd1 : ((i == 9) ? 2'd3 : 2'd2);
      for (int c = 0; c < bc; c++) begin
        @(negedge clk);
        checkOutput($sformatf("bc%0d_bit%0d_cyc%0d_out", bc, i, c), (bc == 1) ? out1 : out4, frame[i]);
        checkOutput($sformatf("bc%0d_bit%0d_busy", bc, i), (bc == 1) ? busy1 : busy4, 1);
        checkOutput($sformatf("bc%0d_bit%0d_state", bc, i), (bc == 1) ? st1 : st4, exp_st);
      end
    end
  endtask

  task automatic checkDone(input int bc);
    @(negedge clk);
    checkOutput("done_pulse", (bc == 1) ? done1 : done4, 1);
    checkOutput("done_ready", (bc == 1) ? rdy1 : rdy4, 1);
    checkOutput("done_out", (bc == 1) ? out1 : out4, 1);
    checkOutput("done_busy", (bc == 1) ? busy1 : busy4, 0);
    checkOutput("done_state", (bc == 1) ? st1 : st4, 0);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, frame: 10'b1_10100101_0, bc: 1};
    vecs[1] = '{data: 8'h00, frame: 10'b1_00000000_0, bc: 1};
    vecs[2] = '{data: 8'hFF, frame: 10'b1_11111111_0, bc: 1};
    vecs[3] = '{data: 8'h01, frame: 10'b1_00000001_0, bc: 4};
    vecs[4] = '{data: 8'hA5, frame: 10'b1_10100101_0, bc: 4};
    vecs[5] = '{data: 8'h3C, frame: 10'b1_00111100_0, bc: 1};

    // Reset held with valid asserted must keep both transmitters idle.
    rst_n  = 1'b0;
    valid1 = 1'b1;
    valid4 = 1'b1;
    data1  = 8'hFF;
    data4  = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out1", out1, 1);
    checkOutput("rst_ready1", rdy1, 1);
    checkOutput("rst_busy1", busy1, 0);
    checkOutput("rst_state1", st1, 0);
    checkOutput("rst_done1", done1, 0);
    checkOutput("rst_out4", out4, 1);
    checkOutput("rst_busy4", busy4, 0);
    valid1 = 1'b0;
    valid4 = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_rst_busy", busy1, 0);
    checkOutput("idle_after_rst_out", out1, 1);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].bc, vecs[v].data, 1'b0);
      checkFrame(vecs[v].bc, vecs[v].frame);
      checkDone(vecs[v].bc);
      @(negedge clk);
      checkOutput("done_cleared", (vecs[v].bc == 1) ? done1 : done4, 0);
      checkOutput("idle_line", (vecs[v].bc == 1) ? out1 : out4, 1);
    end

    // Back-to-back: valid stays high so the second word goes in on the done cycle.
    applyStimulus(1, 8'hFF, 1'b1);
    data1 = 8'h00;
    checkFrame(1, 10'b1_11111111_0);
    checkDone(1);
    fork
      checkFrame(1, 10'b1_00000000_0);
      begin
        @(posedge clk);
        #1 valid1 = 1'b0;
      end
    join
    checkDone(1);
    @(negedge clk);
    checkOutput("b2b_no_third_busy", busy1, 0);
    checkOutput("b2b_done_cleared", done1, 0);

    // Valid toggling and data changes during a frame must not disturb it.
    applyStimulus(1, 8'h3C, 1'b0);
    fork
      checkFrame(1, 10'b1_00111100_0);
      begin
        for (int k = 0; k < 7; k++) begin
          @(posedge clk);
          #2;
          valid1 = ~valid1;
          data1  = 8'hC3;
        end
        valid1 = 1'b0;
      end
    join
    checkDone(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("busy_ignore_idle_busy", busy1, 0);
      checkOutput("busy_ignore_idle_out", out1, 1);
    end

    // Asynchronous reset during data bit 3 aborts the frame between clock edges.
    applyStimulus(1, 8'hA5, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("pre_abort_bit3", out1, 0);
    checkOutput("pre_abort_state", st1, 2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_out", out1, 1);
    checkOutput("abort_state", st1, 0);
    checkOutput("abort_busy", busy1, 0);
    checkOutput("abort_ready", rdy1, 1);
    checkOutput("abort_done", done1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_abort_idle", busy1, 0);
    applyStimulus(1, 8'h5A, 1'b0);
    checkFrame(1, 10'b1_01011010_0);
    checkDone(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
